mob_line_scheduler: RTL

//  Per-scanline sequencer for the motion-object (MOB) table. During line N it walks all
//  16 MOB entries over a registered read port and finds the objects vertically active on

---
 rtl/mob_pkg.sv | 32 +++
 rtl/mob_vhit.sv | 27 ++
 rtl/mob_line_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mob_pkg.sv
// Shared types and constants for the motion-object (MOB) line scheduler.
package mob_pkg;

    localparam int NUM_MOBS = 16;
    localparam int TILE_H   = 8;
    localparam int IDX_W    = $clog2(NUM_MOBS);

    // One entry of the MOB table as returned by the read port
    typedef struct packed {
        logic [7:0] vert;
        logic [7:0] horz;
        logic [7:0] id;
    } mob_entry_t;

    // One slot of the active list handed to the pixel-lookup stage
    typedef struct packed {
        logic       valid;
        logic [7:0] horz;
        logic [7:0] id;
        logic [2:0] row;
        logic       wide;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } sched_state_e;

endpackage

// File: rtl/mob_vhit.sv
// Vertical hit test for one MOB entry against the row being prepared.
// Pure combinational: the distance below the object's top edge decides
// whether the row falls inside the 8- or 16-row object.
module mob_vhit
    import mob_pkg::*;
(
    input  logic [7:0] vert,
    input  logic [7:0] check_row,
    input  logic       is_wide,
    output logic       hit,
    output logic [2:0] row,
    output logic       wide
);

    logic [8:0] offs;
    logic [8:0] height;

    // A negative 9-bit difference means the object starts below the row
    always_comb begin
        offs   = {1'b0, vert} - {1'b0, check_row};
        height = is_wide ? 9'(2 * TILE_H) : 9'(TILE_H);
        hit    = ~offs[8] && (offs < height);
        row    = offs[2:0];
        wide   = offs[3];
    end

endmodule

// File: rtl/mob_line_scheduler.sv
// Per-scanline MOB scheduler: during one line it walks the 16-entry MOB
// table and collects up to MAX_SLOTS objects active on the next line into a
// build list, which is swapped into the displayed list at each line_start.
module mob_line_scheduler
    import mob_pkg::*;
#(
    parameter int                  MAX_SLOTS = 4,
    parameter logic [NUM_MOBS-1:0] WIDE_MASK = 16'h3000,
    parameter logic [7:0]          ROW_FLIP  = 8'd239
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_start,
    input  logic [7:0]             next_row,
    output logic                   rd_en,
    output logic [IDX_W-1:0]       rd_idx,
    input  logic [7:0]             rd_vert,
    input  logic [7:0]             rd_horz,
    input  logic [7:0]             rd_id,
    output logic [MAX_SLOTS-1:0]   slot_valid,
    output logic [MAX_SLOTS*8-1:0] slot_horz,
    output logic [MAX_SLOTS*8-1:0] slot_id,
    output logic [MAX_SLOTS*3-1:0] slot_row,
    output logic [MAX_SLOTS-1:0]   slot_wide,
    output logic                   overflow,
    output logic                   scan_late,
    output logic                   busy
);

    localparam int               FW       = $clog2(MAX_SLOTS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOBS - 1);

    sched_state_e     state_q;
    sched_state_e     state_d;
    logic             eval_valid_q;
    logic [IDX_W-1:0] eval_idx_q;
    logic [7:0]       check_row_q;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;
    logic             build_ovf_q;
    logic             build_ovf_d;
    slot_t            build_q [MAX_SLOTS];
    slot_t            build_d [MAX_SLOTS];
    slot_t            disp_q  [MAX_SLOTS];
    mob_entry_t       rd_entry;
    logic             vhit;
    logic [2:0]       vrow;
    logic             vwide;
    logic             take;

    assign rd_entry = '{vert: rd_vert, horz: rd_horz, id: rd_id};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: line_start always (re)starts a scan, even mid-scan
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (line_start) state_d = SCAN;
            SCAN: begin
                if (line_start)              state_d = SCAN;
                else if (rd_idx == LAST_IDX) state_d = DRAIN;
            end
            DRAIN:   state_d = line_start ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read strobe, busy flag and table index, all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en  <= 1'b0;
            busy   <= 1'b0;
            rd_idx <= '0;
        end else begin
            rd_en <= (state_d == SCAN);
            busy  <= (state_d != IDLE);
            if (line_start)
                rd_idx <= '0;
            else if (state_q == SCAN && rd_idx != LAST_IDX)
                rd_idx <= rd_idx + 1'b1;
        end
    end

    // Track which entry is on the read data bus; a restart discards the read in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            eval_valid_q <= 1'b0;
            eval_idx_q   <= '0;
            check_row_q  <= '0;
        end else begin
            eval_valid_q <= rd_en & ~line_start;
            eval_idx_q   <= rd_idx;
            if (line_start)
                check_row_q <= ROW_FLIP - next_row;
        end
    end

    mob_vhit u_vhit (
        .vert      (rd_entry.vert),
        .check_row (check_row_q),
        .is_wide   (WIDE_MASK[eval_idx_q]),
        .hit       (vhit),
        .row       (vrow),
        .wide      (vwide)
    );

    assign take = eval_valid_q & vhit;

    // Build list with the entry under evaluation appended at the fill pointer
    always_comb begin
        build_d     = build_q;
        fill_d      = fill_q;
        build_ovf_d = build_ovf_q;
        if (take) begin
            if (fill_q == FW'(MAX_SLOTS)) begin
                build_ovf_d = 1'b1;
            end else begin
                for (int i = 0; i < MAX_SLOTS; i++) begin
                    if (fill_q == FW'(i))
                        build_d[i] = '{valid: 1'b1, horz: rd_entry.horz,
                                       id: rd_entry.id, row: vrow, wide: vwide};
                end
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Double buffer: line_start publishes the build list (including the hit in flight) and empties it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                build_q[i] <= SLOT_EMPTY;
                disp_q[i]  <= SLOT_EMPTY;
            end
            fill_q      <= '0;
            build_ovf_q <= 1'b0;
            overflow    <= 1'b0;
            scan_late   <= 1'b0;
        end else if (line_start) begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                disp_q[i]  <= build_d[i];
                build_q[i] <= SLOT_EMPTY;
            end
            fill_q      <= '0;
            build_ovf_q <= 1'b0;
            overflow    <= build_ovf_d;
            scan_late   <= busy;
        end else begin
            for (int i = 0; i < MAX_SLOTS; i++)
                build_q[i] <= build_d[i];
            fill_q      <= fill_d;
            build_ovf_q <= build_ovf_d;
        end
    end

    // Flatten the displayed list onto the slot buses
    always_comb begin
        slot_valid = '0;
        slot_horz  = '0;
        slot_id    = '0;
        slot_row   = '0;
        slot_wide  = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            slot_valid[i]       = disp_q[i].valid;
            slot_horz[i*8 +: 8] = disp_q[i].horz;
            slot_id[i*8 +: 8]   = disp_q[i].id;
            slot_row[i*3 +: 3]  = disp_q[i].row;
            slot_wide[i]        = disp_q[i].wide;
        end
    end

endmodule
